// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, BCD digit type and load saturation helper
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} sw_state_e;
  typedef logic [3:0] bcd_t;
  localparam bcd_t UNITS_MAX = 4'd9;
  localparam bcd_t TENS_MAX = 4'd5;
  function automatic bcd_t sat(bcd_t v, bcd_t m);
    return v > m ? m : v;
  endfunction
endpackage

// File: rtl/sw_digit.sv
// sw_digit: one BCD digit register counting 0..MAX up or down with carry/borrow out
module sw_digit
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = UNITS_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic dir,
  input  logic ld,
  input  logic clr,
  input  bcd_t ld_val,
  output bcd_t q,
  output logic co
);
  bcd_t nxt;
  always_comb nxt = dir ? (q == MAX ? '0 : q + 4'd1) : (q == '0 ? MAX : q - 4'd1);
  assign co = en & (dir ? q == MAX : q == '0);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (clr) q <= '0;
    else if (ld) q <= ld_val;
    else if (en) q <= nxt;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: MM:SS stopwatch sequencer with tick prescaler, start/pause/clear FSM and BCD digit chain
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [3:0]  sec_lo,
  output logic [3:0]  sec_hi,
  output logic [3:0]  min_lo,
  output logic [3:0]  min_hi,
  output logic        running,
  output logic        done,
  output logic        wrap
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW = $clog2(DIV);
  if (DIV < 2 || CLK_HZ % TICK_HZ != 0) begin : g_div_chk
    $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be an integer >= 2");
  end
  sw_state_e state, nxt;
  logic [CW-1:0] cnt;
  logic dir_q, wrap_q, tick, ld_ok, ss, zero, go, resume, down_zero;
  logic [15:0] digits, lv;
  logic [3:0] en, co;
  assign tick = state == RUN && cnt == CW'(DIV - 1);
  assign ld_ok = load & ~clear & (state != RUN);
  assign ss = start_stop & ~clear & ~ld_ok;
  assign zero = digits == 16'h0000;
  assign go = state == IDLE && ss && (up || !zero);
  assign resume = ss & (dir_q | ~zero);
  assign down_zero = tick & ~dir_q & (digits == 16'h0001);
  assign lv = {sat(load_value[15:12], TENS_MAX), sat(load_value[11:8], UNITS_MAX),
               sat(load_value[7:4], TENS_MAX), sat(load_value[3:0], UNITS_MAX)};
  assign en = {co[2:0], tick};
  for (genvar i = 0; i < 4; i++) begin : g_dig
    sw_digit #(.MAX(i % 2 ? TENS_MAX : UNITS_MAX)) u_dig (
      .clk(clk), .reset(reset), .en(en[i]), .dir(dir_q), .ld(ld_ok), .clr(clear),
      .ld_val(lv[4*i+:4]), .q(digits[4*i+:4]), .co(co[i])
    );
  end
  always_comb begin
    nxt = state;
    if (clear) nxt = IDLE;
    else if (ld_ok) nxt = state == PAUSE ? PAUSE : IDLE;
    else
      case (state)
        IDLE:    nxt = go ? RUN : IDLE;
        RUN:     nxt = down_zero ? DONE : ss ? PAUSE : RUN;
        PAUSE:   nxt = resume ? RUN : PAUSE;
        default: nxt = DONE;
      endcase
  end
  // co[3] in up mode means every digit sat at its max on a tick: 59:59 -> 00:00
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      dir_q <= 1'b1;
      wrap_q <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (clear | ld_ok | go | tick) ? '0 : state == RUN ? cnt + 1'b1 : cnt;
      dir_q <= go ? up : dir_q;
      wrap_q <= co[3] & dir_q & ~clear;
    end
  assign {min_hi, min_lo, sec_hi, sec_lo} = digits;
  assign running = state == RUN;
  assign done = state == DONE;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed and random stimulus checked against a seconds-based reference model
module tb_stopwatch_ctrl;
  logic clk = 0, reset = 1, start_stop = 0, clear = 0, up = 1, load = 0;
  logic [15:0] load_value = '0;
  logic [3:0] sec_lo, sec_hi, min_lo, min_hi;
  logic running, done, wrap;
  int checks = 0, passes = 0, fails = 0;
  int m_st, m_sec, m_cnt;
  bit m_dir, m_wrap;
  string phase = "reset";

  always #5 clk = ~clk;

  stopwatch_ctrl #(.CLK_HZ(10), .TICK_HZ(1)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .up(up),
    .load(load), .load_value(load_value), .sec_lo(sec_lo), .sec_hi(sec_hi),
    .min_lo(min_lo), .min_hi(min_hi), .running(running), .done(done), .wrap(wrap)
  );

  // model state: 0 idle, 1 run, 2 pause, 3 done; time kept as total seconds
  function automatic int clampn(int v, int m);
    return v > m ? m : v;
  endfunction

  function automatic int bcd2sec(logic [15:0] v);
    int mm = clampn(int'(v[15:12]), 5) * 10 + clampn(int'(v[11:8]), 9);
    return mm * 60 + clampn(int'(v[7:4]), 5) * 10 + clampn(int'(v[3:0]), 9);
  endfunction

  task automatic m_reset();
    m_st = 0; m_sec = 0; m_cnt = 0; m_dir = 1; m_wrap = 0;
  endtask

  task automatic model_step();
    int s = m_st;
    bit z = m_sec == 0;
    bit tk = s == 1 && m_cnt == 9;
    m_wrap = 0;
    if (clear) begin
      m_st = 0; m_sec = 0; m_cnt = 0;
    end else if (load && s != 1) begin
      m_sec = bcd2sec(load_value); m_cnt = 0; m_st = s == 2 ? 2 : 0;
    end else begin
      if (s == 1) m_cnt = (m_cnt + 1) % 10;
      if (tk && m_dir) begin
        m_wrap = m_sec == 3599;
        m_sec = (m_sec + 1) % 3600;
      end else if (tk) m_sec = m_sec - 1;
      if (s == 1 && tk && !m_dir && m_sec == 0) m_st = 3;
      else if (s == 1 && start_stop) m_st = 2;
      else if (s == 0 && start_stop && (up || !z)) begin
        m_st = 1; m_dir = up; m_cnt = 0;
      end else if (s == 2 && start_stop && (m_dir || !z)) m_st = 1;
    end
  endtask

  task automatic chk(string tag, string f, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) passes++;
    else begin
      fails++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, f, o, e);
    end
  endtask

  task automatic check_all();
    int mm = m_sec / 60, ss = m_sec % 60;
    chk(phase, "sec_lo", 32'(sec_lo), 32'(ss % 10));
    chk(phase, "sec_hi", 32'(sec_hi), 32'(ss / 10));
    chk(phase, "min_lo", 32'(min_lo), 32'(mm % 10));
    chk(phase, "min_hi", 32'(min_hi), 32'(mm / 10));
    chk(phase, "running", 32'(running), 32'(m_st == 1));
    chk(phase, "done", 32'(done), 32'(m_st == 3));
    chk(phase, "wrap", 32'(wrap), 32'(m_wrap));
  endtask

  task automatic cyc(bit ss = 0, bit cl = 0, bit ld = 0, logic [15:0] lv = '0);
    start_stop = ss; clear = cl; load = ld; load_value = lv;
    model_step();
    @(negedge clk);
    start_stop = 0; clear = 0; load = 0;
    check_all();
  endtask

  initial begin
    int wraps, n;
    m_reset();
    repeat (3) @(negedge clk);
    reset = 0;
    check_all();
    chk("reset", "digits", 32'({min_hi, min_lo, sec_hi, sec_lo}), 32'h0);

    phase = "count10"; up = 1;
    cyc(1);
    repeat (100) cyc();
    chk(phase, "sec_lo", 32'(sec_lo), 32'd0);
    chk(phase, "sec_hi", 32'(sec_hi), 32'd1);
    chk(phase, "running", 32'(running), 32'd1);

    phase = "wrap";
    cyc(0, 1);
    cyc(0, 0, 1, 16'h5958);
    cyc(1);
    wraps = 0;
    repeat (25) begin cyc(); wraps += int'(wrap); end
    chk(phase, "digits", 32'({min_hi, min_lo, sec_hi, sec_lo}), 32'h0);
    chk(phase, "wrap_count", 32'(wraps), 32'd1);
    chk(phase, "running", 32'(running), 32'd1);

    phase = "down_done";
    cyc(0, 1);
    cyc(0, 0, 1, 16'h0002);
    up = 0;
    cyc(1);
    repeat (20) cyc();
    chk(phase, "done", 32'(done), 32'd1);
    chk(phase, "running", 32'(running), 32'd0);
    chk(phase, "digits", 32'({min_hi, min_lo, sec_hi, sec_lo}), 32'h0);
    cyc(1);
    chk(phase, "done_held", 32'(done), 32'd1);
    cyc(0, 1);
    chk(phase, "cleared", 32'({done, running}), 32'h0);

    phase = "pause"; up = 1;
    cyc(1);
    repeat (4) cyc();
    cyc(1);
    repeat (50) cyc();
    chk(phase, "digits", 32'({min_hi, min_lo, sec_hi, sec_lo}), 32'h0);
    chk(phase, "running", 32'(running), 32'd0);
    cyc(1);
    n = 0;
    while (sec_lo == 4'd0 && n < 20) begin cyc(); n++; end
    chk(phase, "resume_latency", 32'(n), 32'd5);

    phase = "priority";
    cyc(1, 1, 1, 16'h1234);
    chk(phase, "digits", 32'({min_hi, min_lo, sec_hi, sec_lo}), 32'h0);
    chk(phase, "running", 32'(running), 32'd0);
    cyc(0, 0, 1, 16'hFA7C);
    chk(phase, "sanitise", 32'({min_hi, min_lo, sec_hi, sec_lo}), 32'h5959);
    cyc(0, 1);
    up = 0;
    cyc(1);
    chk(phase, "zero_down_start", 32'({running, done}), 32'h0);
    up = 1;

    phase = "async_reset";
    cyc(0, 0, 1, 16'h5958);
    cyc(1);
    repeat (15) cyc();
    #2 reset = 1;
    m_reset();
    #1;
    check_all();
    chk(phase, "digits", 32'({min_hi, min_lo, sec_hi, sec_lo}), 32'h0);
    @(negedge clk);
    reset = 0;
    wraps = 0;
    repeat (25) begin cyc(); wraps += int'(wrap | done); end
    chk(phase, "no_pulse", 32'(wraps), 32'd0);

    phase = "random";
    repeat (3000) begin
      up = 1'($urandom_range(0, 1));
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
          {4'($urandom_range(0, 6)), 4'($urandom_range(0, 10)),
           4'($urandom_range(0, 6)), 4'($urandom_range(0, 10))});
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
